cs_sequencer: RTL and testbench
===============================

CS_SEQUENCER -- requirements
Module: cs_sequencer

Interface
REQ-001 Parameter DATAWIDTH_CSADDRESS, default 11: control-store address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum memory-wait cycles before trap, range 1..255, 8-bit counter.
REQ-003 Parameter TRAP_ADDRESS, default 11'd2047: control-store address forced on memory timeout.
REQ-004 CSADDRESS_CLOCK_50  in  1  clock; all state updates on rising edge.
REQ-005 CSADDRESS_ResetInHigh_In  in  1  reset, asynchronous, active-high.
REQ-006 CSSEQ_CurrentAddress_InBus  in  11  address currently held in the control-store address register.
REQ-007 CSSEQ_JumpField_InBus  in  11  jump target field of the current microword.
REQ-008 CSSEQ_Cond_InBus  in  3  branch condition: 000 next, 001 N, 010 Z, 011 V, 100 C, 101 IR13, 110 always jump, 111 decode.
REQ-009 CSSEQ_Flags_InBus  in  4  ALU flags {N,Z,V,C}.
REQ-010 CSSEQ_FlagsLoad_In  in  1  latch CSSEQ_Flags_InBus this cycle.
REQ-011 CSSEQ_IR13_In  in  1  instruction-register bit 13.
REQ-012 CSSEQ_MemReq_In  in  1  current microword performs a memory access.
REQ-013 CSSEQ_MemAck_In  in  1  memory access complete.
REQ-014 CSSEQ_Tipo_OutBus  out  2  next-address select: 00 next, 01 jump, 10 decode.
REQ-015 CSSEQ_JumpAddress_OutBus  out  11  address used when select is 01.
REQ-016 CSSEQ_MemStrobe_Out  out  1  memory request to the memory interface.
REQ-017 CSSEQ_Flags_OutBus  out  4  latched flags.
REQ-018 CSSEQ_Timeout_Out  out  1  sticky timeout indicator.

Function
REQ-019 Three-state FSM: RUN, MEM_WAIT, TRAP; the FSM resets to RUN.
REQ-020 Flag register loads CSSEQ_Flags_InBus on a clock edge when FlagsLoad=1 and otherwise holds; branches use only the registered flag value, with no same-cycle bypass.
REQ-021 In the branch decision, condition true gives select 01 with JumpAddress=JumpField, and condition false gives select 00.
REQ-022 In the branch decision, Cond 000 gives select 00, Cond 110 gives 01/JumpField, and Cond 111 gives 10.
REQ-023 The branch decision applies in RUN when MemReq=0, and in RUN when MemReq=1 and MemAck=1 (zero-wait access).
REQ-024 RUN with MemReq=1 and MemAck=0 sets MemStrobe=1 and outputs select 01 with JumpAddress=CurrentAddress (hold).
REQ-025 In the same RUN case (MemReq=1, MemAck=0) the wait counter loads TIMEOUT_CYCLES-1 and the FSM enters MEM_WAIT.
REQ-026 In MEM_WAIT, MemStrobe=1 and the hold (select 01, JumpAddress=CurrentAddress) continues while MemAck=0 and the counter is nonzero; the counter decrements by 1 per cycle.
REQ-027 In MEM_WAIT with MemAck=1, including the cycle the counter reaches 0, the branch decision applies, MemStrobe=1, and the FSM enters RUN; ack wins over timeout.
REQ-028 In MEM_WAIT with counter=0 and MemAck=0, the outputs are select 01 and JumpAddress=TRAP_ADDRESS, MemStrobe=0, Timeout is set, and the FSM enters TRAP.
REQ-029 TRAP lasts exactly one cycle and outputs select 00 (continue from trap routine), MemStrobe=0, then the FSM enters RUN; MemReq is ignored in TRAP.
REQ-030 Timeout stays 1 until reset; there is no other clear.
REQ-031 MemStrobe is 0 in RUN whenever MemReq=0.
REQ-032 Select and JumpAddress outputs are combinational (Mealy), and the downstream address register adds one cycle of latency.
REQ-033 When not selecting 01, JumpAddress=JumpField.

Reset
REQ-034 On reset assertion the FSM goes to RUN, flags to 0000, wait counter to 0, and Timeout to 0 immediately, independent of the clock.
REQ-035 Reset asserted mid MEM_WAIT aborts the access and drops MemStrobe in the same cycle (outputs follow the RUN decode with MemReq sampled).

Structure
REQ-036 Shared package holds the FSM state encoding, the Cond encodings (000..111), the select encodings (00/01/10), and the defaults for DATAWIDTH_CSADDRESS and TRAP_ADDRESS.
REQ-037 One sub-module, cs_branch_cond (combinational, Cond+flags+IR13 -> select), is natural; the rest is flat.

Verification
REQ-038 Reset, then Cond=000 and MemReq=0 -> select 00, MemStrobe 0, Flags 0000, Timeout 0.
REQ-039 Flags=1000 with FlagsLoad pulse, next cycle Cond=001 and JumpField=0x123 -> select 01, JumpAddress 0x123; with Flags=0100, Cond=001 -> select 00.
REQ-040 MemReq=1 with MemAck low for 3 cycles then high, Cond=110, JumpField=0x050, CurrentAddress=0x010 -> the first cycles hold with JumpAddress 0x010 and MemStrobe 1, and the ack cycle gives select 01 with JumpAddress 0x050.
REQ-041 TIMEOUT_CYCLES=4 with MemAck never asserted -> 4 hold cycles, then JumpAddress 0x7FF with select 01, Timeout 1 sticky, TRAP for 1 cycle, then RUN.
REQ-042 MemReq=1 and MemAck=1 in the same RUN cycle with Cond=111 -> select 10, no MEM_WAIT entry.
REQ-043 Reset pulsed during MEM_WAIT -> MemStrobe 0 immediately, state RUN, counter 0, Flags 0000.

Source files
------------

// File: rtl/cs_sequencer_pkg.sv
// Shared encodings and defaults for the control-store sequencer.
package cs_sequencer_pkg;

    localparam int          CS_AW_DEF     = 11;
    localparam logic [10:0] TRAP_ADDR_DEF = 11'd2047;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } seq_state_t;

    // Branch condition field of the microword
    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_DECODE = 3'b111
    } cond_t;

    // Next-address select presented to the address mux
    typedef enum logic [1:0] {
        SEL_NEXT   = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_DECODE = 2'b10
    } sel_t;

    // Latched ALU flags, bit order {N,Z,V,C}
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/cs_sequencer_branch_cond.sv
// Combinational branch decision: condition code + registered flags + IR13 -> select.
module cs_branch_cond
    import cs_sequencer_pkg::*;
(
    input  logic [2:0] cond,
    input  flags_t     flags,
    input  logic       ir13,
    output sel_t       sel
);

    // Map each condition code to next/jump/decode
    always_comb begin
        sel = SEL_NEXT;
        case (cond)
            COND_NEXT:   sel = SEL_NEXT;
            COND_N:      sel = flags.n ? SEL_JUMP : SEL_NEXT;
            COND_Z:      sel = flags.z ? SEL_JUMP : SEL_NEXT;
            COND_V:      sel = flags.v ? SEL_JUMP : SEL_NEXT;
            COND_C:      sel = flags.c ? SEL_JUMP : SEL_NEXT;
            COND_IR13:   sel = ir13    ? SEL_JUMP : SEL_NEXT;
            COND_ALWAYS: sel = SEL_JUMP;
            COND_DECODE: sel = SEL_DECODE;
            default:     sel = SEL_NEXT;
        endcase
    end

endmodule

// File: rtl/cs_sequencer.sv
// Control-store next-address sequencer with memory-wait hold and timeout trap.
module cs_sequencer
    import cs_sequencer_pkg::*;
#(
    parameter int                             DATAWIDTH_CSADDRESS = CS_AW_DEF,
    parameter int                             TIMEOUT_CYCLES      = 255,
    parameter logic [DATAWIDTH_CSADDRESS-1:0] TRAP_ADDRESS        = TRAP_ADDR_DEF
) (
    input  logic                           CSADDRESS_CLOCK_50,
    input  logic                           CSADDRESS_ResetInHigh_In,
    input  logic [DATAWIDTH_CSADDRESS-1:0] CSSEQ_CurrentAddress_InBus,
    input  logic [DATAWIDTH_CSADDRESS-1:0] CSSEQ_JumpField_InBus,
    input  logic [2:0]                     CSSEQ_Cond_InBus,
    input  logic [3:0]                     CSSEQ_Flags_InBus,
    input  logic                           CSSEQ_FlagsLoad_In,
    input  logic                           CSSEQ_IR13_In,
    input  logic                           CSSEQ_MemReq_In,
    input  logic                           CSSEQ_MemAck_In,
    output logic [1:0]                     CSSEQ_Tipo_OutBus,
    output logic [DATAWIDTH_CSADDRESS-1:0] CSSEQ_JumpAddress_OutBus,
    output logic                           CSSEQ_MemStrobe_Out,
    output logic [3:0]                     CSSEQ_Flags_OutBus,
    output logic                           CSSEQ_Timeout_Out
);

    // Counter reload: the RUN cycle that raises the request is the first hold
    // cycle, so MEM_WAIT covers the remaining TIMEOUT_CYCLES-1.
    localparam logic [7:0] CNT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    flags_t     flags_q;
    logic       timeout_q;
    logic       timeout_set;
    sel_t       br_sel;
    sel_t       sel;
    logic       strobe;
    logic [DATAWIDTH_CSADDRESS-1:0] jaddr;

    cs_branch_cond u_branch_cond (
        .cond  (CSSEQ_Cond_InBus),
        .flags (flags_q),
        .ir13  (CSSEQ_IR13_In),
        .sel   (br_sel)
    );

    // Flag register: branches only ever see the registered value
    always_ff @(posedge CSADDRESS_CLOCK_50 or posedge CSADDRESS_ResetInHigh_In) begin
        if (CSADDRESS_ResetInHigh_In)
            flags_q <= '0;
        else if (CSSEQ_FlagsLoad_In)
            flags_q <= flags_t'(CSSEQ_Flags_InBus);
    end

    // FSM state, wait counter and sticky timeout
    always_ff @(posedge CSADDRESS_CLOCK_50 or posedge CSADDRESS_ResetInHigh_In) begin
        if (CSADDRESS_ResetInHigh_In) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set)
                timeout_q <= 1'b1;
        end
    end

    // Next-state and Mealy output decode
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;
        sel         = SEL_NEXT;
        jaddr       = CSSEQ_JumpField_InBus;
        strobe      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (CSSEQ_MemReq_In && !CSSEQ_MemAck_In) begin
                    // hold the current microword until memory answers
                    strobe     = 1'b1;
                    sel        = SEL_JUMP;
                    jaddr      = CSSEQ_CurrentAddress_InBus;
                    wait_cnt_d = CNT_LOAD;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    // no access, or zero-wait access completes now
                    sel    = br_sel;
                    strobe = CSSEQ_MemReq_In;
                end
            end
            ST_MEM_WAIT: begin
                if (CSSEQ_MemAck_In) begin
                    // ack wins even on the cycle the counter hits zero
                    sel        = br_sel;
                    strobe     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_RUN;
                end else if (wait_cnt_q != '0) begin
                    strobe     = 1'b1;
                    sel        = SEL_JUMP;
                    jaddr      = CSSEQ_CurrentAddress_InBus;
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end else begin
                    // give up on the access and vector to the trap routine
                    sel         = SEL_JUMP;
                    jaddr       = TRAP_ADDRESS;
                    timeout_set = 1'b1;
                    state_d     = ST_TRAP;
                end
            end
            ST_TRAP: begin
                // one cycle to let the trap routine start; MemReq ignored
                sel     = SEL_NEXT;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Strobe is forced low while reset is asserted so an in-flight access
    // is abandoned immediately.
    assign CSSEQ_MemStrobe_Out      = strobe & ~CSADDRESS_ResetInHigh_In;
    assign CSSEQ_Tipo_OutBus        = sel;
    assign CSSEQ_JumpAddress_OutBus = jaddr;
    assign CSSEQ_Flags_OutBus       = flags_q;
    assign CSSEQ_Timeout_Out        = timeout_q;

endmodule

// File: tb/tb_cs_sequencer.sv
// Scoreboard bench for cs_sequencer: stimulus pushes expectations, monitor checks.
module tb_cs_sequencer;

    logic        clk;
    logic        rst;
    logic [10:0] cur_addr;
    logic [10:0] jump_field;
    logic [2:0]  cond;
    logic [3:0]  flags_in;
    logic        flags_load;
    logic        ir13;
    logic        mem_req;
    logic        mem_ack;
    logic [1:0]  tipo;
    logic [10:0] jump_addr;
    logic        mem_strobe;
    logic [3:0]  flags_out;
    logic        timeout;

    typedef struct {
        logic [1:0]  sel;
        logic [10:0] ja;
        logic        stb;
        logic [3:0]  fl;
        logic        tmo;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   vec_n   = 0;
    int   n_check = 0;
    int   n_err   = 0;
    logic fin_req = 1'b0;

    cs_sequencer #(
        .DATAWIDTH_CSADDRESS (11),
        .TIMEOUT_CYCLES      (4),
        .TRAP_ADDRESS        (11'd2047)
    ) dut (
        .CSADDRESS_CLOCK_50         (clk),
        .CSADDRESS_ResetInHigh_In   (rst),
        .CSSEQ_CurrentAddress_InBus (cur_addr),
        .CSSEQ_JumpField_InBus      (jump_field),
        .CSSEQ_Cond_InBus           (cond),
        .CSSEQ_Flags_InBus          (flags_in),
        .CSSEQ_FlagsLoad_In         (flags_load),
        .CSSEQ_IR13_In              (ir13),
        .CSSEQ_MemReq_In            (mem_req),
        .CSSEQ_MemAck_In            (mem_ack),
        .CSSEQ_Tipo_OutBus          (tipo),
        .CSSEQ_JumpAddress_OutBus   (jump_addr),
        .CSSEQ_MemStrobe_Out        (mem_strobe),
        .CSSEQ_Flags_OutBus         (flags_out),
        .CSSEQ_Timeout_Out          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus, driven just after the rising edge, with its expectation
    task automatic cyc(input logic r, input logic [2:0] c, input logic [10:0] jf,
                       input logic [10:0] ca, input logic mr, input logic ma,
                       input logic fld, input logic [3:0] fi, input logic ir,
                       input logic [1:0] e_sel, input logic [10:0] e_ja,
                       input logic e_stb, input logic [3:0] e_fl, input logic e_tmo);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        cond       = c;
        jump_field = jf;
        cur_addr   = ca;
        mem_req    = mr;
        mem_ack    = ma;
        flags_load = fld;
        flags_in   = fi;
        ir13       = ir;
        e.sel = e_sel; e.ja = e_ja; e.stb = e_stb; e.fl = e_fl; e.tmo = e_tmo;
        e.tag = vec_n;
        vec_n = vec_n + 1;
        exp_q.push_back(e);
    endtask

    // Directed check at the current sampling point
    task automatic chk(input string nm, input logic ok);
        n_check = n_check + 1;
        if (ok !== 1'b1) begin
            n_err = n_err + 1;
            $display("FAIL %s: sel=%b ja=%h stb=%b fl=%b tmo=%b",
                     nm, tipo, jump_addr, mem_strobe, flags_out, timeout);
        end
    endtask

    // Monitor: sample mid-cycle, compare against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_check = n_check + 1;
            if (tipo !== e.sel || jump_addr !== e.ja || mem_strobe !== e.stb ||
                flags_out !== e.fl || timeout !== e.tmo) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d: got sel=%b ja=%h stb=%b fl=%b tmo=%b want sel=%b ja=%h stb=%b fl=%b tmo=%b",
                         e.tag, tipo, jump_addr, mem_strobe, flags_out, timeout,
                         e.sel, e.ja, e.stb, e.fl, e.tmo);
            end
        end else if (fin_req) begin
            $display("Simulation finished: %0d checks, %0d errors", n_check, n_err);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; cur_addr = '0; jump_field = '0; cond = '0; flags_in = '0;
        flags_load = 1'b0; ir13 = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

        // reset state, then release
        cyc(1, 3'd0, 11'h3AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h3AA, 0, 4'h0, 0);
        @(negedge clk);
        #1;
        chk("reset_state", tipo == 2'b00 && mem_strobe == 1'b0 &&
                           flags_out == 4'h0 && timeout == 1'b0);
        cyc(0, 3'd0, 11'h3AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h3AA, 0, 4'h0, 0);

        // flag load has no same-cycle bypass
        cyc(0, 3'd1, 11'h123, 11'h000, 0, 0, 1, 4'h8, 0, 2'b00, 11'h123, 0, 4'h0, 0);
        cyc(0, 3'd1, 11'h123, 11'h000, 0, 0, 0, 4'h0, 0, 2'b01, 11'h123, 0, 4'h8, 0);
        cyc(0, 3'd1, 11'h123, 11'h000, 0, 0, 1, 4'h4, 0, 2'b01, 11'h123, 0, 4'h8, 0);
        cyc(0, 3'd1, 11'h123, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h123, 0, 4'h4, 0);
        // each condition against flags 0100 then 0011
        cyc(0, 3'd2, 11'h155, 11'h000, 0, 0, 0, 4'h0, 0, 2'b01, 11'h155, 0, 4'h4, 0);
        cyc(0, 3'd3, 11'h155, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h155, 0, 4'h4, 0);
        cyc(0, 3'd4, 11'h155, 11'h000, 0, 0, 1, 4'h3, 0, 2'b00, 11'h155, 0, 4'h4, 0);
        cyc(0, 3'd3, 11'h2AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b01, 11'h2AA, 0, 4'h3, 0);
        cyc(0, 3'd4, 11'h2AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b01, 11'h2AA, 0, 4'h3, 0);
        cyc(0, 3'd2, 11'h2AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h2AA, 0, 4'h3, 0);
        cyc(0, 3'd1, 11'h2AA, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h2AA, 0, 4'h3, 0);
        cyc(0, 3'd5, 11'h0F0, 11'h000, 0, 0, 0, 4'h0, 1, 2'b01, 11'h0F0, 0, 4'h3, 0);
        cyc(0, 3'd5, 11'h0F0, 11'h000, 0, 0, 0, 4'h0, 0, 2'b00, 11'h0F0, 0, 4'h3, 0);
        cyc(0, 3'd6, 11'h0F0, 11'h000, 0, 0, 0, 4'h0, 0, 2'b01, 11'h0F0, 0, 4'h3, 0);
        cyc(0, 3'd7, 11'h0F0, 11'h000, 0, 0, 0, 4'h0, 0, 2'b10, 11'h0F0, 0, 4'h3, 0);

        // memory wait, ack after 3 low cycles
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h3, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h3, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h3, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 1, 0, 4'h0, 0, 2'b01, 11'h050, 1, 4'h3, 0);
        cyc(0, 3'd0, 11'h050, 11'h010, 0, 0, 0, 4'h0, 0, 2'b00, 11'h050, 0, 4'h3, 0);

        // ack on the cycle the counter reaches zero wins over timeout
        cyc(0, 3'd7, 11'h200, 11'h020, 1, 0, 0, 4'h0, 0, 2'b01, 11'h020, 1, 4'h3, 0);
        cyc(0, 3'd7, 11'h200, 11'h020, 1, 0, 0, 4'h0, 0, 2'b01, 11'h020, 1, 4'h3, 0);
        cyc(0, 3'd7, 11'h200, 11'h020, 1, 0, 0, 4'h0, 0, 2'b01, 11'h020, 1, 4'h3, 0);
        cyc(0, 3'd7, 11'h200, 11'h020, 1, 0, 0, 4'h0, 0, 2'b01, 11'h020, 1, 4'h3, 0);
        cyc(0, 3'd7, 11'h200, 11'h020, 1, 1, 0, 4'h0, 0, 2'b10, 11'h200, 1, 4'h3, 0);
        cyc(0, 3'd0, 11'h200, 11'h020, 0, 0, 0, 4'h0, 0, 2'b00, 11'h200, 0, 4'h3, 0);

        // zero-wait access, no MEM_WAIT entry
        cyc(0, 3'd7, 11'h321, 11'h030, 1, 1, 0, 4'h0, 0, 2'b10, 11'h321, 1, 4'h3, 0);
        cyc(0, 3'd0, 11'h321, 11'h030, 0, 0, 0, 4'h0, 0, 2'b00, 11'h321, 0, 4'h3, 0);

        // reset in the middle of MEM_WAIT
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h3, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h3, 0);
        cyc(1, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 0, 4'h0, 0);
        cyc(1, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 0, 4'h0, 0);
        cyc(0, 3'd0, 11'h050, 11'h010, 0, 0, 0, 4'h0, 0, 2'b00, 11'h050, 0, 4'h0, 0);

        // timeout: 4 hold cycles, trap vector, TRAP, back to RUN, sticky flag
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h0, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h0, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h0, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h010, 1, 4'h0, 0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b01, 11'h7FF, 0, 4'h0, 0);
        @(negedge clk);
        #1;
        chk("expired_wait", tipo == 2'b01 && jump_addr == 11'h7FF &&
                            mem_strobe == 1'b0 && timeout == 1'b0);
        cyc(0, 3'd6, 11'h050, 11'h010, 1, 0, 0, 4'h0, 0, 2'b00, 11'h050, 0, 4'h0, 1);
        cyc(0, 3'd7, 11'h060, 11'h010, 0, 0, 0, 4'h0, 0, 2'b10, 11'h060, 0, 4'h0, 1);
        cyc(0, 3'd0, 11'h060, 11'h010, 0, 0, 0, 4'h0, 0, 2'b00, 11'h060, 0, 4'h0, 1);
        cyc(0, 3'd0, 11'h060, 11'h010, 1, 1, 0, 4'h0, 0, 2'b00, 11'h060, 1, 4'h0, 1);

        @(posedge clk);
        fin_req = 1'b1;
    end

endmodule
